// File: rtl/bus_txn_fifo.sv
// First-word-fall-through buffer for the sub_module transaction stream; 1-cycle push-to-output latency.
// No upstream backpressure: a write arriving while full (and not popping) is dropped and counted.
package my_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 16;

  typedef struct packed {
    logic                  valid;
    logic                  ready;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } bus_transaction_t;
endpackage

module bus_txn_fifo
  import my_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DROP_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  bus_transaction_t           bus_in,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic [ADDR_WIDTH-1:0]      out_addr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  output logic [DROP_W-1:0]          drop_cnt
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = DATA_WIDTH + ADDR_WIDTH;

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  logic push, pop, drop;
  logic unused_bus_ready;

  // The upstream ready is meaningless here; this stage can never stall the producer.
  assign unused_bus_ready = bus_in.ready;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign out_valid = !empty;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

  assign pop  = out_valid && out_ready;
  assign push = bus_in.valid && (!full || pop);
  assign drop = bus_in.valid && full && !pop;

  // Head is forced to zero when empty so stale storage never leaks onto the bus.
  assign out_data = empty ? '0 : mem_q[rd_ptr_q][ENTRY_W-1:ADDR_WIDTH];
  assign out_addr = empty ? '0 : mem_q[rd_ptr_q][ADDR_WIDTH-1:0];

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DROP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {bus_in.data, bus_in.addr};
  end

endmodule

// File: tb/tb_bus_txn_fifo.sv
// Scoreboard bench for bus_txn_fifo: a default instance plus a DROP_W=2 instance sharing the same stimulus.
module tb_bus_txn_fifo;
  import my_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  bus_transaction_t bus_in;
  logic out_ready;

  logic [DATA_WIDTH-1:0] out_data, s_out_data;
  logic [ADDR_WIDTH-1:0] out_addr, s_out_addr;
  logic                  out_valid, s_out_valid;
  logic [2:0]            count, s_count;
  logic                  full, s_full, empty, s_empty, overflow, s_overflow;
  logic [7:0]            drop_cnt;
  logic [1:0]            s_drop_cnt;

  always #5 clk = ~clk;

  bus_txn_fifo #(.DEPTH(DEPTH), .DROP_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus_in(bus_in),
    .out_data(out_data), .out_addr(out_addr), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .full(full), .empty(empty), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  bus_txn_fifo #(.DEPTH(DEPTH), .DROP_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .bus_in(bus_in),
    .out_data(s_out_data), .out_addr(s_out_addr), .out_valid(s_out_valid), .out_ready(out_ready),
    .count(s_count), .full(s_full), .empty(s_empty), .overflow(s_overflow), .drop_cnt(s_drop_cnt)
  );

  typedef struct {
    logic [31:0] d;
    logic [15:0] a;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   mcount = 0;
  int   mdrop  = 0;
  bit   movf   = 1'b0;

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_state();
    chk("count",      64'(count),      64'(mcount));
    chk("empty",      64'(empty),      64'(mcount == 0));
    chk("full",       64'(full),       64'(mcount == DEPTH));
    chk("out_valid",  64'(out_valid),  64'(mcount != 0));
    chk("overflow",   64'(overflow),   64'(movf));
    chk("drop_cnt",   64'(drop_cnt),   64'(sat(mdrop, 255)));
    chk("s_count",    64'(s_count),    64'(mcount));
    chk("s_valid",    64'(s_out_valid), 64'(mcount != 0));
    chk("s_full",     64'(s_full),     64'(mcount == DEPTH));
    chk("s_empty",    64'(s_empty),    64'(mcount == 0));
    chk("s_overflow", 64'(s_overflow), 64'(movf));
    chk("s_drop_cnt", 64'(s_drop_cnt), 64'(sat(mdrop, 3)));
  endtask

  // One clock: check registered state, drive inputs, update the model, step past the edge.
  task automatic cycle(input bit v, input logic [31:0] d, input logic [15:0] a, input bit rdy);
    bit popm, pushm;
    check_state();
    bus_in.valid = v;
    bus_in.ready = ~v;
    bus_in.data  = d;
    bus_in.addr  = a;
    out_ready    = rdy;
    popm  = (mcount > 0) && rdy;
    pushm = v && ((mcount < DEPTH) || popm);
    if (pushm) exp_q.push_back('{d, a});
    if (v && !pushm) begin
      mdrop++;
      movf = 1'b1;
    end
    mcount += int'(pushm) - int'(popm);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit rdy);
    cycle(1'b0, 32'hDEAD_BEEF, 16'hFFFF, rdy);
  endtask

  task automatic fill(input int base);
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'(base + i), 16'(16'h0100 + base + i), 1'b0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) idle(1'b1);
  endtask

  // Monitor: head must match the oldest expected entry whenever valid; zero when not.
  always @(negedge clk) begin
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL head_unexpected: got data %0h addr %0h, required no valid entry", out_data, out_addr);
      end else begin
        chk("head_data",   64'(out_data),   64'(exp_q[0].d));
        chk("head_addr",   64'(out_addr),   64'(exp_q[0].a));
        chk("s_head_data", 64'(s_out_data), 64'(exp_q[0].d));
        chk("s_head_addr", 64'(s_out_addr), 64'(exp_q[0].a));
        if (out_ready) void'(exp_q.pop_front());
      end
    end else begin
      chk("idle_head", {16'h0, out_data, out_addr}, 64'h0);
    end
  end

  initial begin
    rst_n        = 1'b0;
    bus_in       = '0;
    out_ready    = 1'b0;
    #1;
    check_state();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single transaction, held for three cycles, then consumed.
    cycle(1'b1, 32'h0000_0011, 16'h0A0A, 1'b0);
    repeat (3) idle(1'b0);
    idle(1'b1);
    idle(1'b0);

    // Fill and ordered drain.
    fill(1);
    idle(1'b0);
    drain(4);
    idle(1'b0);

    // Overflow while full: three drops, contents intact, overflow sticky across a pop.
    fill(1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'(32'hD0 + i), 16'hDDDD, 1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b0);
    drain(3);
    idle(1'b0);

    // Full with simultaneous push and pop: no drop, order preserved.
    fill(1);
    cycle(1'b1, 32'h5, 16'h0105, 1'b1);
    idle(1'b0);
    drain(4);
    idle(1'b0);

    // Asynchronous reset mid-stream with three entries buffered.
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'(32'h30 + i), 16'h0300, 1'b0);
    check_state();
    #1 rst_n = 1'b0;
    exp_q.delete();
    mcount = 0;
    mdrop  = 0;
    movf   = 1'b0;
    #1;
    check_state();
    chk("rst_head", {16'h0, out_data, out_addr}, 64'h0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    bus_in.valid = 1'b0;
    @(posedge clk);
    #1;

    // Six drops: wide counter reaches 6, narrow counter saturates at 3.
    fill(1);
    for (int i = 0; i < 6; i++) cycle(1'b1, 32'(32'hE0 + i), 16'hEEEE, 1'b0);
    idle(1'b0);
    drain(4);
    idle(1'b0);

    // Random traffic against the queue model.
    for (int i = 0; i < 10000; i++) begin
      bit rdy;
      rdy = (i < 5000) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
      cycle(1'($urandom_range(0, 1)), $urandom, 16'($urandom_range(0, 65535)), rdy);
      chk("count_range", 64'(count <= 3'(DEPTH)), 64'd1);
    end
    drain(DEPTH);
    idle(1'b0);
    check_state();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
